// File: rtl/apb_regfile_slave.sv
// APB completer: NUM_RW read/write registers, NUM_RO read-only status words, wait states, pslverr.
// Optional byte-strobe support is enabled by defining APB_REGFILE_PSTRB_EN.
module apb_regfile_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_RW      = 4,
    parameter int NUM_RO      = 2,
    parameter int WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int RO_CNT     = (NUM_RO > 0) ? NUM_RO : 1
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [DATA_W-1:0]        pwdata,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0]      pstrb,
`endif
    output logic                     pready,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pslverr,
    input  logic [RO_CNT*DATA_W-1:0] ro_data,
    output logic [NUM_RW*DATA_W-1:0] rw_data,
    output logic [NUM_RW-1:0]        wr_pulse
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         cnt;
    logic [3:0]         next_cnt;
    logic [31:0]        idx;
    logic               is_rw;
    logic               is_ro;
    logic               complete;
    logic               wr_en;
    logic [DATA_W/8-1:0] lane_en;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // A setup phase is required to leave IDLE; dropping psel in ACCESS aborts.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pready     = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    next_state = ACCESS;
                    next_cnt   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                pready = (cnt == 4'd0);
                if (!psel) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else if (penable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // The two ignored address bits still pass through the shift, so every paddr bit is consumed.
    assign idx      = 32'(paddr >> 2);
    assign is_rw    = (idx < NUM_RW);
    assign is_ro    = !is_rw && (idx < NUM_RW + NUM_RO);
    assign complete = pready && psel && penable;
    assign wr_en    = complete && pwrite && is_rw;

`ifdef APB_REGFILE_PSTRB_EN
    assign lane_en = pstrb;
`else
    assign lane_en = '1;
`endif

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (pready) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (idx == 32'(i)) prdata = rw_data[i*DATA_W +: DATA_W];
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if (idx == 32'(NUM_RW + k)) prdata = ro_data[k*DATA_W +: DATA_W];
            end
            pslverr = pwrite ? !is_rw : !(is_rw || is_ro);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            rw_data  <= {NUM_RW{RESET_VAL}};
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_en && idx == 32'(i)) begin
                    wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < DATA_W/8; b++) begin
                        if (lane_en[b]) rw_data[i*DATA_W + b*8 +: 8] <= pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: directed vector table, hand-written corner
// sequences and randomized transfers against an array-based register model.
module tb_apb_regfile_slave;

    logic         pclk = 1'b0;
    logic         preset;
    logic         psel, penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [63:0]  ro_data;
    logic         pready, pslverr;
    logic [31:0]  prdata;
    logic [127:0] rw_data;
    logic [3:0]   wr_pulse;

    logic         psel3, penable3, pwrite3;
    logic [7:0]   paddr3;
    logic [31:0]  pwdata3;
    logic [3:0]   pstrb3;
    logic         pready3, pslverr3;
    logic [31:0]  prdata3;
    logic [127:0] rw_data3;
    logic [3:0]   wr_pulse3;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_rw [4];
    logic [3:0]  post_pulse;

    typedef struct {
        logic        wr;
        int          idx;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs [13];

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .NUM_RW(4), .NUM_RO(2),
                        .WAIT_STATES(0), .RESET_VAL(32'h0)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .ro_data(ro_data), .rw_data(rw_data), .wr_pulse(wr_pulse)
    );

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .NUM_RW(4), .NUM_RO(2),
                        .WAIT_STATES(3), .RESET_VAL(32'h0)) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable3), .pwrite(pwrite3),
        .paddr(paddr3), .pwdata(pwdata3),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb3),
`endif
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
        .ro_data(ro_data), .rw_data(rw_data3), .wr_pulse(wr_pulse3)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model_rw[3], model_rw[2], model_rw[1], model_rw[0]};
    endfunction

    function automatic logic [31:0] ref_read(input int idx, input logic [63:0] ro);
        if (idx < 4) return model_rw[idx];
        if (idx == 4) return ro[31:0];
        if (idx == 5) return ro[63:32];
        return 32'h0;
    endfunction

    function automatic logic ref_err(input logic wr, input int idx);
        return wr ? (idx >= 4) : (idx >= 6);
    endfunction

    // Effects of the previous completed transfer are visible in the cycle after it.
    task automatic checkPost(input string name);
        checkOutput({name, " wr_pulse"}, wr_pulse, post_pulse);
        checkOutput({name, " rw_data"}, rw_data, model_flat());
        post_pulse = '0;
    endtask

    // Starts just after a rising edge and returns just after the completing edge.
    task automatic applyStimulus(input string name, input logic wr, input int idx,
                                 input logic [31:0] wd, input logic [3:0] st,
                                 input logic [63:0] ro_n, input logic [31:0] exp_rd,
                                 input logic exp_err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = 8'(idx*4 + int'($urandom_range(0, 3)));
        pwdata  = wd;
        pstrb   = st;
        @(negedge pclk);
        checkPost(name);
        checkOutput({name, " setup pready"}, pready, 1'b0);
        @(posedge pclk); #1;
        penable = 1'b1;
        ro_data = ro_n;
        @(negedge pclk);
        checkOutput({name, " pready"}, pready, 1'b1);
        checkOutput({name, " pslverr"}, pslverr, exp_err);
        if (!wr) checkOutput({name, " prdata"}, prdata, exp_rd);
        @(posedge pclk); #1;
        post_pulse = '0;
        if (wr && idx < 4) begin
`ifdef APB_REGFILE_PSTRB_EN
            for (int b = 0; b < 4; b++) if (st[b]) model_rw[idx][b*8 +: 8] = wd[b*8 +: 8];
`else
            model_rw[idx] = wd;
`endif
            post_pulse[idx] = 1'b1;
        end
    endtask

    task automatic idleCycle(input string name);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        checkPost(name);
        checkOutput({name, " idle pready"}, pready, 1'b0);
        @(posedge pclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        wr;
        int          idx;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [63:0] ro_n;

        vecs[0]  = '{1'b0, 0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 2, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 3, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1, 2, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 2, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b1, 5, 32'h55555555, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 9, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b0, 4, 32'h0,        32'h00001234, 1'b0};
        vecs[9]  = '{1'b0, 5, 32'h0,        32'hCAFE0005, 1'b0};
        vecs[10] = '{1'b1, 0, 32'h000000A5, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 0, 32'h0,        32'h000000A5, 1'b0};
        vecs[12] = '{1'b1, 40, 32'h12345678, 32'h0,       1'b1};

        for (int i = 0; i < 4; i++) model_rw[i] = 32'h0;
        post_pulse = '0;
        preset  = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        psel3 = 1'b0; penable3 = 1'b0; pwrite3 = 1'b0; paddr3 = '0; pwdata3 = '0; pstrb3 = '0;
        ro_data = 64'hCAFE0005_00001234;

        repeat (2) @(posedge pclk);
        @(negedge pclk);
        checkOutput("reset pready", pready, 1'b0);
        checkOutput("reset prdata", prdata, 32'h0);
        checkOutput("reset pslverr", pslverr, 1'b0);
        checkOutput("reset rw_data", rw_data, 128'h0);
        checkOutput("reset wr_pulse", wr_pulse, 4'h0);
        checkOutput("reset pready3", pready3, 1'b0);
        @(posedge pclk); #1;
        preset = 1'b0;

        // Vectors run back to back: each setup lands right after the previous completion.
        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].idx, vecs[i].wd, 4'hF,
                          64'hCAFE0005_00001234, vecs[i].rd, vecs[i].err);
        end
        idleCycle("vec_end");

        // psel with penable but no setup phase must not start a transfer.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF;
        @(negedge pclk);
        checkOutput("nosetup pready", pready, 1'b0);
        @(posedge pclk); #1;
        idleCycle("nosetup");

        // Reset in the completing cycle of a write suppresses the write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF;
        @(negedge pclk);
        checkPost("rstmid");
        @(posedge pclk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(negedge pclk);
        checkOutput("rstmid completing pready", pready, 1'b1);
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) model_rw[i] = 32'h0;
        post_pulse = '0;
        @(negedge pclk);
        checkPost("rstmid after");
        checkOutput("rstmid after pready", pready, 1'b0);
        @(posedge pclk); #1;

        // Three wait states on the second instance, RO word 0 sampled at completion.
        ro_data = 64'h0_00001234;
        psel3 = 1'b1; penable3 = 1'b0; pwrite3 = 1'b0; paddr3 = 8'h10;
        @(negedge pclk);
        checkOutput("ws3 setup pready", pready3, 1'b0);
        @(posedge pclk); #1;
        penable3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checkOutput($sformatf("ws3 wait%0d pready", i), pready3, 1'b0);
            checkOutput($sformatf("ws3 wait%0d prdata", i), prdata3, 32'h0);
            @(posedge pclk); #1;
        end
        @(negedge pclk);
        checkOutput("ws3 done pready", pready3, 1'b1);
        checkOutput("ws3 done prdata", prdata3, 32'h00001234);
        checkOutput("ws3 done pslverr", pslverr3, 1'b0);
        @(posedge pclk); #1;
        psel3 = 1'b0; penable3 = 1'b0;
        @(negedge pclk);
        checkOutput("ws3 after pready", pready3, 1'b0);
        @(posedge pclk); #1;

        // Abort during wait states, then a bare access phase must stay ignored.
        psel3 = 1'b1; penable3 = 1'b0; pwrite3 = 1'b1; paddr3 = 8'h04; pwdata3 = 32'h0BADF00D;
        @(posedge pclk); #1;
        psel3 = 1'b0;
        @(posedge pclk); #1;
        psel3 = 1'b1; penable3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            checkOutput($sformatf("abort%0d pready", i), pready3, 1'b0);
            @(posedge pclk); #1;
        end
        psel3 = 1'b0; penable3 = 1'b0;
        @(negedge pclk);
        checkOutput("abort rw_data", rw_data3, 128'h0);
        checkOutput("abort wr_pulse", wr_pulse3, 4'h0);
        @(posedge pclk); #1;

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, 9));
            wd   = $urandom;
            st   = 4'($urandom_range(0, 15));
            ro_n = {$urandom, $urandom};
            applyStimulus($sformatf("rnd%0d", n), wr, idx, wd, st, ro_n,
                          ref_read(idx, ro_n), ref_err(wr, idx));
            if ($urandom_range(0, 3) == 0) idleCycle($sformatf("rnd%0d_idle", n));
        end
        idleCycle("rnd_end");

`ifdef APB_REGFILE_PSTRB_EN
        applyStimulus("strb_full", 1'b1, 1, 32'h11223344, 4'hF, ro_data, 32'h0, 1'b0);
        applyStimulus("strb_0101", 1'b1, 1, 32'hAABBCCDD, 4'h5, ro_data, 32'h0, 1'b0);
        applyStimulus("strb_rd1", 1'b0, 1, 32'h0, 4'h0, ro_data, 32'h11BB33DD, 1'b0);
        applyStimulus("strb_none", 1'b1, 1, 32'hFFFFFFFF, 4'h0, ro_data, 32'h0, 1'b0);
        applyStimulus("strb_rd2", 1'b0, 1, 32'h0, 4'hF, ro_data, 32'h11BB33DD, 1'b0);
        idleCycle("strb_end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
